// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM state type and alignment check for load_store_unit.
`default_nettype none

package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_RESP = 2'b11
   } lsu_state_t;

   // Size 11 is illegal and counts as an error alongside true misalignment.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = offset[0];
         SZ_WORD: bad = (offset != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational little-endian lane extraction/extension for loads
// and lane merge into a buffered word for sub-word stores.
`default_nettype none

module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merge_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_word[7:0];
      case (i_offset)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
      w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

      o_load_data = i_word;
      case (i_size)
         SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
         SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
         default: o_load_data = i_word;
      endcase

      // Word stores bypass the buffer entirely.
      o_merge_data = i_wdata;
      case (i_size)
         SZ_BYTE: begin
            o_merge_data = i_word;
            o_merge_data[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
         end
         SZ_HALF: begin
            o_merge_data = i_word;
            o_merge_data[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
         end
         default: o_merge_data = i_wdata;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end to a word-addressed memory,
// with read-modify-write for sub-word stores and sign/zero-extended loads.
`default_nettype none

module load_store_unit
   import lsu_pkg::*;
#(
   parameter int RD_LAT = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_write,
   input  logic [1:0]  i_req_size,
   input  logic        i_req_signed,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_resp_valid,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_write_data,
   output logic        o_mem_write,
   output logic        o_mem_read,
   input  logic [31:0] i_mem_read_data
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(RD_LAT - 1);

   lsu_state_t       r_state;
   lsu_state_t       w_state_nxt;
   logic             r_ready;
   logic             r_write;
   logic [1:0]       r_size;
   logic             r_signed;
   logic [1:0]       r_offset;
   logic [31:0]      r_wdata;
   logic             r_err;
   logic [31:0]      r_mem_addr;
   logic [31:0]      r_buf;
   logic [CNT_W-1:0] r_cnt;

   logic             w_accept;
   logic             w_req_err;
   logic [31:0]      w_load_data;
   logic [31:0]      w_merge_data;

   assign w_accept  = i_req_valid & r_ready;
   assign w_req_err = is_misaligned(i_req_size, i_req_addr[1:0]);

   lsu_lane_align u_align (
      .i_size       (r_size),
      .i_signed     (r_signed),
      .i_offset     (r_offset),
      .i_word       (r_buf),
      .i_wdata      (r_wdata),
      .o_load_data  (w_load_data),
      .o_merge_data (w_merge_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      o_mem_read       = 1'b0;
      o_mem_write      = 1'b0;
      o_mem_write_data = 32'h0;
      o_resp_valid     = 1'b0;
      o_resp_rdata     = 32'h0;
      o_resp_err       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_req_err)
                  w_state_nxt = ST_RESP;
               else if (i_req_write && (i_req_size == SZ_WORD))
                  w_state_nxt = ST_WR;
               else
                  w_state_nxt = ST_RD;
            end
         end
         ST_RD: begin
            o_mem_read = 1'b1;
            if (r_cnt == '0)
               w_state_nxt = r_write ? ST_WR : ST_RESP;
         end
         ST_WR: begin
            o_mem_write      = 1'b1;
            o_mem_write_data = w_merge_data;
            w_state_nxt      = ST_RESP;
         end
         default: begin
            o_resp_valid = 1'b1;
            o_resp_err   = r_err;
            o_resp_rdata = (r_err || r_write) ? 32'h0 : w_load_data;
            w_state_nxt  = ST_IDLE;
         end
      endcase
   end

   // Ready is registered so it stays low through reset and rises one edge after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready    <= 1'b0;
         r_write    <= 1'b0;
         r_size     <= 2'b00;
         r_signed   <= 1'b0;
         r_offset   <= 2'b00;
         r_wdata    <= 32'h0;
         r_err      <= 1'b0;
         r_mem_addr <= 32'h0;
         r_buf      <= 32'h0;
         r_cnt      <= '0;
      end else begin
         r_ready <= (w_state_nxt == ST_IDLE);
         if (w_accept) begin
            r_write    <= i_req_write;
            r_size     <= i_req_size;
            r_signed   <= i_req_signed;
            r_offset   <= i_req_addr[1:0];
            r_wdata    <= i_req_wdata;
            r_err      <= w_req_err;
            r_mem_addr <= {2'b00, i_req_addr[31:2]};
            r_buf      <= 32'h0;
            r_cnt      <= c_cnt_init;
         end else if (r_state == ST_RD) begin
            if (r_cnt == '0)
               r_buf <= i_mem_read_data;
            else
               r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign o_req_ready = r_ready;
   assign o_mem_addr  = r_mem_addr;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with RD_LAT = 1.
`default_nettype none

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_read_data;

   logic [31:0] mem [0:15];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   load_store_unit #(.RD_LAT(1)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_req_valid      (req_valid),
      .o_req_ready      (req_ready),
      .i_req_write      (req_write),
      .i_req_size       (req_size),
      .i_req_signed     (req_signed),
      .i_req_addr       (req_addr),
      .i_req_wdata      (req_wdata),
      .o_resp_valid     (resp_valid),
      .o_resp_rdata     (resp_rdata),
      .o_resp_err       (resp_err),
      .o_mem_addr       (mem_addr),
      .o_mem_write_data (mem_write_data),
      .o_mem_write      (mem_write),
      .o_mem_read       (mem_read),
      .i_mem_read_data  (mem_read_data)
   );

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[3:0]] <= mem_write_data;
   end
   assign mem_read_data = mem_read ? mem[mem_addr[3:0]] : 32'h0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int exp_reads, input int exp_writes, input logic [31:0] exp_wd);
      int lat = 0;
      int reads = 0;
      int writes = 0;
      int viol = 0;
      int tries = 0;
      logic [31:0] wd = 32'h0;
      logic [31:0] rd = 32'h0;
      logic [31:0] ma = 32'h0;
      logic        er = 1'b0;
      @(negedge clk);
      while (!req_ready && tries < 50) begin
         @(negedge clk);
         tries++;
      end
      check({tag, " ready"}, 32'(req_ready), 32'd1);
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = addr;
      req_wdata  = wdata;
      req_valid  = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = 32'hDEAD_BEEF;
      req_wdata = 32'hDEAD_BEEF;
      for (int e = 1; e <= 20; e++) begin
         @(negedge clk);
         if (mem_read) reads++;
         if (mem_write) begin
            writes++;
            wd = mem_write_data;
         end else if (mem_write_data != 32'h0) begin
            viol++;
         end
         if (mem_read && mem_write) viol++;
         if (resp_valid) begin
            lat = e;
            rd  = resp_rdata;
            er  = resp_err;
            ma  = mem_addr;
            break;
         end
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " rdata"}, rd, exp_rdata);
      check({tag, " err"}, 32'(er), 32'(exp_err));
      check({tag, " reads"}, 32'(reads), 32'(exp_reads));
      check({tag, " writes"}, 32'(writes), 32'(exp_writes));
      check({tag, " wdata"}, wd, exp_wd);
      check({tag, " mem_addr"}, ma, {2'b00, addr[31:2]});
      check({tag, " strobe rules"}, 32'(viol), 32'd0);
      @(negedge clk);
      check({tag, " resp pulse"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[1] = 32'h8081_82FF;

      repeat (2) @(negedge clk);
      check("reset ready", 32'(req_ready), 32'd0);
      check("reset resp_valid", 32'(resp_valid), 32'd0);
      check("reset mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
      check("reset mem_addr", mem_addr, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("ready after reset", 32'(req_ready), 32'd1);

      //         tag            wr    sz     sg    addr   wdata         rdata         err  lat rd wr wdata
      run_req("lw 4",        1'b0, 2'b10, 1'b0, 32'h4, 32'h0,        32'h8081_82FF, 1'b0, 2, 1, 0, 32'h0);
      run_req("lb 4",        1'b0, 2'b00, 1'b1, 32'h4, 32'h0,        32'hFFFF_FFFF, 1'b0, 2, 1, 0, 32'h0);
      run_req("lbu 5",       1'b0, 2'b00, 1'b0, 32'h5, 32'h0,        32'h0000_0082, 1'b0, 2, 1, 0, 32'h0);
      run_req("lh 6",        1'b0, 2'b01, 1'b1, 32'h6, 32'h0,        32'hFFFF_8081, 1'b0, 2, 1, 0, 32'h0);
      run_req("lhu 6",       1'b0, 2'b01, 1'b0, 32'h6, 32'h0,        32'h0000_8081, 1'b0, 2, 1, 0, 32'h0);
      run_req("sb 5",        1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB, 32'h0,        1'b0, 3, 1, 1, 32'h8081_ABFF);
      run_req("lw after sb", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0,        32'h8081_ABFF, 1'b0, 2, 1, 0, 32'h0);
      run_req("sw 4",        1'b1, 2'b10, 1'b0, 32'h4, 32'h0000_0008, 32'h0,        1'b0, 2, 0, 1, 32'h0000_0008);
      run_req("lw after sw", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0,        32'h0000_0008, 1'b0, 2, 1, 0, 32'h0);
      run_req("sh 6",        1'b1, 2'b01, 1'b0, 32'h6, 32'hFFFF_1234, 32'h0,        1'b0, 3, 1, 1, 32'h1234_0008);
      run_req("lh 4 pos",    1'b0, 2'b01, 1'b1, 32'h4, 32'h0,        32'h0000_0008, 1'b0, 2, 1, 0, 32'h0);
      run_req("err lw 6",    1'b0, 2'b10, 1'b0, 32'h6, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
      run_req("err lh 5",    1'b0, 2'b01, 1'b1, 32'h5, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
      run_req("err size11",  1'b1, 2'b11, 1'b0, 32'h4, 32'h5555_5555, 32'h0,        1'b1, 1, 0, 0, 32'h0);

      // Abort a sub-word store while it sits in the write cycle.
      @(negedge clk);
      req_write  = 1'b1;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'h4;
      req_wdata  = 32'h0000_00CD;
      req_valid  = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("abort in WR", 32'(mem_write), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("abort write drop", {30'b0, mem_read, mem_write}, 32'd0);
      check("abort resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort ready", 32'(req_ready), 32'd1);
      begin
         int seen = 0;
         repeat (4) begin
            @(negedge clk);
            if (resp_valid) seen++;
         end
         check("abort no resp", 32'(seen), 32'd0);
      end
      run_req("lw after abort", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h1234_0008, 1'b0, 2, 1, 0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface. Accepts byte-addressed load/store requests from the processor datapath, converts them to word-addressed `memory` accesses (`addr`, `write_data`, `MemWrite`, `MemRead`, `read_data`), and returns the results. Word memory supports only full-word writes, so byte and halfword stores use read-modify-write. Loads are sign- or zero-extended. Misaligned accesses are rejected without touching memory.

## Interface
- `RD_LAT`, 1: cycles `mem_read` and `mem_addr` are held before `mem_read_data` is sampled (≥1).
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready` at a rising edge.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_signed`  in  1  loads only: 1 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle pulse; no backpressure.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal size; valid with `resp_valid`.
- `mem_addr`  out  32  word address = `req_addr >> 2`.
- `mem_write_data`  out  32  full word to write.
- `mem_write`  out  1  memory write strobe.
- `mem_read`  out  1  memory read strobe.
- `mem_read_data`  in  32  memory read data.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE, on accept:
  - Latch the request.
  - Error (`size`=11, half with `addr[0]`≠0, word with `addr[1:0]`≠0) → RESP with err.
  - Word store → WR.
  - Otherwise (load or sub-word store) → RD.
- RD:
  - `mem_read`=1 for exactly RD_LAT cycles, counted by a down-counter.
  - `mem_read_data` is captured into the word buffer at the edge ending the last RD cycle.
  - Then load → RESP; sub-word store → WR.
- WR:
  - `mem_write`=1 for exactly one cycle.
  - Write data is `req_wdata` for word stores, or the buffered word with the target lane replaced for sub-word stores.
  - Then → RESP.
- RESP: `resp_valid`=1 for one cycle, then → IDLE. `req_ready` is 0, so back-to-back accept happens on the following cycle.
- Byte lanes are little-endian:
  - Byte offset n maps to bits [8n+7:8n].
  - Half offset 0 maps to [15:0]; offset 2 maps to [31:16].
- Load extraction: the selected lane is shifted to bit 0, then sign-extended if `req_signed`, else zero-extended. A word load passes through.
- `mem_read` and `mem_write` are never high together.
- Outside WR, `mem_write_data` is 0.
- `mem_addr` is registered at accept, held through RESP, and 0 after reset.
- An error response performs no memory access.

## Timing
- Accept edge = edge 0. `resp_valid` is high in the cycle after:
  - Load: edge RD_LAT+1.
  - Word store: edge 2.
  - Sub-word store: edge RD_LAT+2.
  - Error: edge 1.
- Reset values: state IDLE, all outputs 0. `req_ready` rises in the first cycle after `rst` deasserts.
- Reset mid-operation:
  - Asynchronous abort: `mem_read`, `mem_write` and `resp_valid` drop immediately.
  - The buffer and counter are cleared.
  - The in-flight request is lost and produces no response.
- `req_valid` while not ready is ignored; the requester must hold it.
- `req_*` inputs are only sampled at the accept edge.

## Structure
- Package `lsu_pkg` holds:
  - The size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`).
  - The FSM state enum.
  - The misalignment-check function.
- Sub-module `lsu_lane_align` is combinational. It produces:
  - The extract/extend path for loads.
  - The lane merge for stores.
- Top level holds the FSM, the RD_LAT counter, the request latch and the word buffer.

## Test plan
Memory preload: word 1 = 0x808182FF. RD_LAT = 1.
- lw @0x4 → `mem_read`=1 with `mem_addr`=1 for one cycle; `resp_valid` at edge 2 with `resp_rdata`=0x808182FF, `resp_err`=0.
- Signed and unsigned sub-word loads:
  - lb signed @0x4 → 0xFFFFFFFF.
  - lbu @0x5 → 0x00000082.
  - lh signed @0x6 → 0xFFFF8081.
  - lhu @0x6 → 0x00008081.
- sb 0x000000AB @0x5 → one `mem_read` cycle, then one `mem_write` cycle with `mem_write_data`=0x8081ABFF; `resp_valid` at edge 3. A following lw @0x4 returns 0x8081ABFF.
- sw 0x00000008 @0x4 → no `mem_read`; `mem_write`=1 with data 0x00000008 at `mem_addr` 1; response at edge 2. A following lw returns 0x00000008.
- Error requests (lw @0x6, lh @0x5, size 11) → `resp_valid` and `resp_err`=1 at edge 1 with `resp_rdata`=0; no `mem_read` or `mem_write`.
- `rst` asserted during WR of a sub-word store → `mem_write` falls immediately without a clock edge; no response is generated; `req_ready`=1 one cycle after release. The memory word is unchanged if the reset precedes the write edge.
